flit_injector: RTL and testbench



---
 rtl/noc_pkg.sv | 26 ++
 rtl/flit_fifo.sv | 59 +++++
 rtl/flit_injector.sv | 107 ++++++++++
 tb/tb_flit_injector.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: flit layout and credit sizing shared by the NoC link-layer blocks (rev 1.0).
`default_nettype none

`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

package noc_pkg;

  localparam int FLIT_DATA_WIDTH = `FLIT_DATA_WIDTH;
  localparam int MESH_ROUTERS    = 16;
  localparam int MESH_ID_BITS    = $clog2(MESH_ROUTERS);

  typedef struct packed {
    logic [MESH_ID_BITS-1:0]                 dest;
    logic [FLIT_DATA_WIDTH-MESH_ID_BITS-1:0] payload;
  } flit_t;

  // Width needed to hold every credit value from 0 to num_vc inclusive.
  function automatic int credit_width(input int num_vc);
    return $clog2(num_vc + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/flit_fifo.sv
// flit_fifo: synchronous FIFO with a registered array and extra-bit wrap pointers (rev 1.0).
`default_nettype none

module flit_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Same index with differing wrap bits means the writer is a full lap ahead.
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

`default_nettype wire

// File: rtl/flit_injector.sv
// flit_injector: credit-based flit transmitter feeding one router input port (rev 1.0).
`default_nettype none

module flit_injector
  import noc_pkg::*;
#(
  parameter int NUM_VC         = 4,
  parameter int NUM_ROUTERS    = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int ROUTER_ID_BITS = $clog2(NUM_ROUTERS),
  parameter int CRED_BITS      = credit_width(NUM_VC)
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      core_valid,
  output logic                                      core_ready,
  input  logic [ROUTER_ID_BITS-1:0]                 core_dest,
  input  logic [FLIT_DATA_WIDTH-ROUTER_ID_BITS-1:0] core_payload,
  input  logic                                      credit_in,
  output logic [FLIT_DATA_WIDTH-1:0]                out_data,
  output logic                                      out_valid,
  output logic [CRED_BITS-1:0]                      credit_count,
  output logic                                      credit_err,
  output logic [7:0]                                drop_count
);

  localparam logic [ROUTER_ID_BITS:0] DEST_LIMIT = (ROUTER_ID_BITS+1)'(NUM_ROUTERS);
  localparam logic [CRED_BITS-1:0]    CRED_MAX   = CRED_BITS'(NUM_VC);

  logic                       fifo_full, fifo_empty;
  logic [FLIT_DATA_WIDTH-1:0] head_data;
  logic                       accept, dest_illegal, push, pop;

  logic [CRED_BITS-1:0]       credit_q, credit_d;
  logic                       credit_err_q, credit_err_d;
  logic [7:0]                 drop_q, drop_d;
  logic                       out_valid_q, out_valid_d;
  logic [FLIT_DATA_WIDTH-1:0] out_data_q, out_data_d;

  flit_fifo #(
    .WIDTH (FLIT_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({core_dest, core_payload}),
    .pop       (pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    core_ready   = !fifo_full;
    accept       = core_valid && !fifo_full;
    dest_illegal = ({1'b0, core_dest} >= DEST_LIMIT);
    push         = accept && !dest_illegal;
    // Pop eligibility uses the registered count; a credit arriving now only counts next edge.
    pop          = !fifo_empty && (credit_q != '0);

    out_valid_d  = pop;
    out_data_d   = pop ? head_data : out_data_q;

    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    if (credit_in && !pop) begin
      if (credit_q == CRED_MAX) begin
        credit_err_d = 1'b1;
      end else begin
        credit_d = credit_q + CRED_BITS'(1);
      end
    end else if (!credit_in && pop) begin
      credit_d = credit_q - CRED_BITS'(1);
    end

    drop_d = drop_q;
    if (accept && dest_illegal && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      credit_q     <= CRED_MAX;
      credit_err_q <= 1'b0;
      drop_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
      drop_q       <= drop_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign credit_count = credit_q;
  assign credit_err   = credit_err_q;
  assign drop_count   = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_flit_injector.sv
// tb_flit_injector: scenario tasks plus random traffic against a queue-based link model.
`default_nettype none

module tb_flit_injector;
  import noc_pkg::*;

  localparam int NUM_VC      = 4;
  localparam int NUM_ROUTERS = 16;
  localparam int FIFO_DEPTH  = 4;
  localparam int ID_BITS     = 5;  // wide enough that dest=16 is representable
  localparam int CRED_BITS   = credit_width(NUM_VC);
  localparam int FW          = FLIT_DATA_WIDTH;
  localparam int PW          = FW - ID_BITS;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 core_valid = 1'b0;
  logic                 credit_in = 1'b0;
  logic [ID_BITS-1:0]   core_dest = '0;
  logic [PW-1:0]        core_payload = '0;
  logic                 core_ready;
  logic [FW-1:0]        out_data;
  logic                 out_valid;
  logic [CRED_BITS-1:0] credit_count;
  logic                 credit_err;
  logic [7:0]           drop_count;

  flit_injector #(
    .NUM_VC         (NUM_VC),
    .NUM_ROUTERS    (NUM_ROUTERS),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .ROUTER_ID_BITS (ID_BITS),
    .CRED_BITS      (CRED_BITS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .core_valid   (core_valid),
    .core_ready   (core_ready),
    .core_dest    (core_dest),
    .core_payload (core_payload),
    .credit_in    (credit_in),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .credit_count (credit_count),
    .credit_err   (credit_err),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: queue of buffered flits, credit integer, sticky error, drop tally.
  logic [FW-1:0] m_q[$];
  int            m_credit = NUM_VC;
  bit            m_err = 1'b0;
  int            m_drop = 0;
  bit            m_ov = 1'b0;
  logic [FW-1:0] m_od = '0;

  int total = 0;
  int bad   = 0;

  function automatic bit exp_ready();
    return m_q.size() < FIFO_DEPTH;
  endfunction

  // Advance the model by one edge using the currently driven inputs, then clock the DUT.
  task automatic step();
    bit rdy;
    bit pop;
    if (!reset) begin
      m_q.delete();
      m_credit = NUM_VC;
      m_err    = 1'b0;
      m_drop   = 0;
      m_ov     = 1'b0;
      m_od     = '0;
    end else begin
      rdy  = exp_ready();
      pop  = (m_q.size() > 0) && (m_credit > 0);
      m_ov = pop;
      if (pop) m_od = m_q.pop_front();
      if (core_valid && rdy) begin
        if (int'(core_dest) >= NUM_ROUTERS) begin
          if (m_drop < 255) m_drop++;
        end else begin
          m_q.push_back({core_dest, core_payload});
        end
      end
      m_credit = m_credit + (credit_in ? 1 : 0) - (pop ? 1 : 0);
      if (m_credit > NUM_VC) begin
        m_credit = NUM_VC;
        m_err    = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; core_valid = 1'b0; credit_in = 1'b0;
    step(); step();
    reset = 1'b1;
    total++; if (core_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", core_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    total++; if (credit_count !== CRED_BITS'(NUM_VC)) begin bad++; $display("FAIL reset_credit got=%0d exp=%0d", credit_count, NUM_VC); end
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL reset_credit_err got=%b exp=0", credit_err); end
    total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int first  = -1;
    int last   = -1;
    for (int i = 0; i < 8; i++) begin
      core_valid   = (i < 4);
      core_dest    = ID_BITS'(5);
      core_payload = PW'($urandom());
      step();
      total++; if (out_valid !== m_ov) begin bad++; $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", i, out_valid, m_ov); end
      if (m_ov) begin
        total++; if (out_data !== m_od) begin bad++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", i, out_data, m_od); end
      end
      if (out_valid === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        last = i;
      end
    end
    total++; if (pulses != 4 || first != 1 || last != 4) begin bad++; $display("FAIL b2b_pulses got=%0d@%0d..%0d exp=4@1..4", pulses, first, last); end
    total++; if (credit_count !== CRED_BITS'(0)) begin bad++; $display("FAIL b2b_credit got=%0d exp=0", credit_count); end
    // With no credits left, further flits must sit in the FIFO.
    for (int i = 0; i < 4; i++) begin
      core_valid   = 1'b1;
      core_dest    = ID_BITS'($urandom_range(0, NUM_ROUTERS - 1));
      core_payload = PW'($urandom());
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_hold_valid cyc=%0d got=%b exp=0", i, out_valid); end
    end
    core_valid = 1'b0;
    total++; if (core_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready got=%b exp=0", core_ready); end
  endtask

  task automatic test_fill_and_credit();
    core_valid   = 1'b1;
    core_dest    = ID_BITS'(9);
    core_payload = PW'($urandom());
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (core_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL fill_stall cyc=%0d ready=%b valid=%b exp=0/0", i, core_ready, out_valid); end
    end
    credit_in = 1'b1;
    step();
    credit_in = 1'b0;
    total++; if (out_valid !== 1'b0 || credit_count !== CRED_BITS'(1)) begin bad++; $display("FAIL credit_from_zero valid=%b credit=%0d exp=0/1", out_valid, credit_count); end
    step();
    total++; if (out_valid !== 1'b1 || out_data !== m_od) begin bad++; $display("FAIL credit_emit valid=%b data=%h exp=1/%h", out_valid, out_data, m_od); end
    total++; if (credit_count !== CRED_BITS'(0) || core_ready !== 1'b1) begin bad++; $display("FAIL credit_emit_state credit=%0d ready=%b exp=0/1", credit_count, core_ready); end
    step();
    core_valid = 1'b0;
    total++; if (core_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL fifth_accept ready=%b valid=%b exp=0/0", core_ready, out_valid); end
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL credit_single cyc=%0d got=%b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_credit_same_edge();
    reset = 1'b0; step(); reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      core_valid   = 1'b1;
      core_dest    = ID_BITS'($urandom_range(0, NUM_ROUTERS - 1));
      core_payload = PW'($urandom());
      step();
    end
    core_valid = 1'b0;
    total++; if (credit_count !== CRED_BITS'(2)) begin bad++; $display("FAIL same_edge_pre got=%0d exp=2", credit_count); end
    credit_in = 1'b1;
    step();
    total++; if (credit_count !== CRED_BITS'(2)) begin bad++; $display("FAIL same_edge_credit got=%0d exp=2", credit_count); end
    total++; if (out_valid !== 1'b1 || out_data !== m_od) begin bad++; $display("FAIL same_edge_send valid=%b data=%h exp=1/%h", out_valid, out_data, m_od); end
    step(); step(); step();
    credit_in = 1'b0;
    total++; if (credit_count !== CRED_BITS'(NUM_VC) || credit_err !== 1'b1) begin bad++; $display("FAIL overflow credit=%0d err=%b exp=%0d/1", credit_count, credit_err, NUM_VC); end
    step(); step(); step();
    total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", credit_err); end
  endtask

  task automatic test_drop();
    core_valid   = 1'b1;
    core_dest    = ID_BITS'(16);
    core_payload = PW'($urandom());
    total++; if (core_ready !== 1'b1) begin bad++; $display("FAIL drop_ready got=%b exp=1", core_ready); end
    step();
    core_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drop_no_send cyc=%0d got=%b exp=0", i, out_valid); end
    end
    total++; if (drop_count !== 8'd1) begin bad++; $display("FAIL drop_one got=%0d exp=1", drop_count); end
    for (int i = 0; i < 300; i++) begin
      core_valid = 1'b1;
      core_dest  = ID_BITS'($urandom_range(NUM_ROUTERS, 31));
      step();
    end
    core_valid = 1'b0;
    total++; if (drop_count !== 8'd255 || core_ready !== 1'b1) begin bad++; $display("FAIL drop_sat got=%0d ready=%b exp=255/1", drop_count, core_ready); end
  endtask

  task automatic test_reset_midop();
    int sent = 0;
    int cyc  = 0;
    bit acc;
    reset = 1'b0; step(); reset = 1'b1;
    core_dest    = ID_BITS'($urandom_range(0, NUM_ROUTERS - 1));
    core_payload = PW'($urandom());
    while (sent < 6 && cyc < 50) begin
      core_valid = 1'b1;
      acc = exp_ready();
      step();
      cyc++;
      if (acc) begin
        sent++;
        core_dest    = ID_BITS'($urandom_range(0, NUM_ROUTERS - 1));
        core_payload = PW'($urandom());
      end
    end
    total++; if (sent < 6) begin bad++; $display("FAIL midop_fill_timeout sent=%0d exp=6", sent); end
    credit_in = 1'b1;
    step();
    credit_in  = 1'b0;
    core_valid = 1'b0;
    total++; if (credit_count !== CRED_BITS'(1)) begin bad++; $display("FAIL midop_pre credit=%0d exp=1", credit_count); end
    reset = 1'b0;
    step();
    reset = 1'b1;
    total++; if (out_valid !== 1'b0 || credit_count !== CRED_BITS'(NUM_VC) || core_ready !== 1'b1) begin bad++; $display("FAIL midop_reset valid=%b credit=%0d ready=%b exp=0/%0d/1", out_valid, credit_count, core_ready, NUM_VC); end
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midop_stale cyc=%0d got=%b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_random();
    reset = 1'b0; step(); reset = 1'b1;
    for (int i = 0; i < 600; i++) begin
      core_valid   = ($urandom_range(0, 9) < 7);
      core_dest    = ($urandom_range(0, 7) == 0) ? ID_BITS'($urandom_range(NUM_ROUTERS, 31))
                                                 : ID_BITS'($urandom_range(0, NUM_ROUTERS - 1));
      core_payload = PW'($urandom());
      credit_in    = ($urandom_range(0, 99) < 45);
      step();
      total++; if (core_ready !== exp_ready()) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, core_ready, exp_ready()); end
      total++; if (out_valid !== m_ov) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, out_valid, m_ov); end
      total++; if (out_data !== m_od) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", i, out_data, m_od); end
      total++; if (credit_count !== CRED_BITS'(m_credit)) begin bad++; $display("FAIL rnd_credit cyc=%0d got=%0d exp=%0d", i, credit_count, m_credit); end
      total++; if (credit_err !== m_err) begin bad++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", i, credit_err, m_err); end
      total++; if (drop_count !== 8'(m_drop)) begin bad++; $display("FAIL rnd_drop cyc=%0d got=%0d exp=%0d", i, drop_count, m_drop); end
    end
    core_valid = 1'b0;
    credit_in  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_fill_and_credit();
    test_credit_same_edge();
    test_drop();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
